// File: rtl/i2c_reg_master.sv
// i2c_reg_master: I2C master issuing single-byte register writes and reads to one 7-bit slave.
// Each bit is four quarter ticks; outputs are registered open-drain enables.
module i2c_reg_master #(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          I2C_FREQ = 100_000,
  parameter logic [6:0]  DEV_ADDR = 7'h60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_fin,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_fin,
  output logic       rd_ack,
  output logic       scl_oe,
  input  logic       scl_i,
  output logic       sda_oe,
  input  logic       sda_i
);
  localparam int QRAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QDIV = QRAW < 1 ? 1 : QRAW;
  localparam int DW = QDIV > 1 ? $clog2(QDIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(QDIV - 1);
  typedef enum logic [2:0] {IDLE, START, BYTE, RSTART, STOP, DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] q_q, q_d, idx_q, idx_d;
  logic [3:0] bit_q, bit_d;
  logic [2:0] idle_q, idle_d;
  logic is_rd_q, is_rd_d, ack_q, ack_d;
  logic [7:0] addr_q, addr_d, data_q, data_d, rx_q, rx_d, rd_data_q, rd_data_d;
  logic scl_m_q, scl_s_q, sda_m_q, sda_s_q;
  logic scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d, want_sda;
  logic wr_fin_q, wr_fin_d, wr_ack_q, wr_ack_d, rd_fin_q, rd_fin_d, rd_ack_q, rd_ack_d;
  logic tick, accept, step, ack_bit, nack, fin, cur_bit, byte_end;
  logic [7:0] tx_byte;
  // A quarter only ends once a released SCL is seen high, which stretches the bit for a slow slave.
  assign tick = div_q == DMAX && (scl_oe_q || scl_s_q);
  assign accept = state_q == IDLE && idle_q == 3'd4 && (wr_req || rd_req);
  assign step = tick && q_q == (state_q == START ? 2'd1 : 2'd3);
  assign ack_bit = bit_q == 4'd8;
  assign byte_end = state_q == BYTE && step && ack_bit;
  assign nack = sda_s_q && idx_q != 2'd3;
  assign fin = state_q == STOP && step;
  assign tx_byte = idx_q == 2'd0 ? {DEV_ADDR, 1'b0} : idx_q == 2'd1 ? addr_q :
                   is_rd_q ? {DEV_ADDR, 1'b1} : data_q;
  assign cur_bit = tx_byte[3'd7 - bit_q[2:0]];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      q_q       <= '0;
      idx_q     <= '0;
      bit_q     <= '0;
      idle_q    <= '0;
      is_rd_q   <= 1'b0;
      ack_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      scl_m_q   <= 1'b1;
      scl_s_q   <= 1'b1;
      sda_m_q   <= 1'b1;
      sda_s_q   <= 1'b1;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_fin_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_fin_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      q_q       <= q_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      idle_q    <= idle_d;
      is_rd_q   <= is_rd_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      scl_m_q   <= scl_i;
      scl_s_q   <= scl_m_q;
      sda_m_q   <= sda_i;
      sda_s_q   <= sda_m_q;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
      wr_fin_q  <= wr_fin_d;
      wr_ack_q  <= wr_ack_d;
      rd_fin_q  <= rd_fin_d;
      rd_ack_q  <= rd_ack_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? START : IDLE;
      START:   state_d = step ? BYTE : START;
      BYTE:    state_d = !byte_end ? BYTE :
                         (nack || idx_q == 2'd3 || (!is_rd_q && idx_q == 2'd2)) ? STOP :
                         (is_rd_q && idx_q == 2'd1) ? RSTART : BYTE;
      RSTART:  state_d = step ? BYTE : RSTART;
      STOP:    state_d = step ? DONE : STOP;
      DONE:    state_d = (is_rd_q ? !rd_req : !wr_req) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    div_d = accept ? '0 : div_q != DMAX ? div_q + DW'(1) : tick ? '0 : div_q;
    q_d = state_d != state_q ? 2'd0 : tick ? q_q + 2'd1 : q_q;
    bit_d = accept ? 4'd0 : (state_q == BYTE && step) ? (ack_bit ? 4'd0 : bit_q + 4'd1) : bit_q;
    idx_d = accept ? 2'd0 : byte_end ? idx_q + 2'd1 : idx_q;
    ack_d = accept ? 1'b1 : (byte_end && nack) ? 1'b0 : ack_q;
    rx_d = (state_q == BYTE && step && !ack_bit && idx_q == 2'd3) ? {rx_q[6:0], sda_s_q} : rx_q;
    is_rd_d = accept ? !wr_req : is_rd_q;
    addr_d = accept ? (wr_req ? wr_addr : rd_addr) : addr_q;
    data_d = (accept && wr_req) ? wr_data : data_q;
    // Bus-free counter runs in DONE and IDLE so a START always follows at least four idle quarters.
    idle_d = (state_q == IDLE || state_q == DONE) ?
             ((tick && idle_q != 3'd4) ? idle_q + 3'd1 : idle_q) : 3'd0;
    wr_fin_d = fin && !is_rd_q;
    rd_fin_d = fin && is_rd_q;
    wr_ack_d = wr_fin_d && ack_q;
    rd_ack_d = rd_fin_d && ack_q;
    rd_data_d = (rd_fin_d && ack_q) ? rx_q : rd_data_q;
  end
  always_comb begin
    scl_oe_d = (state_q == BYTE || state_q == RSTART || state_q == STOP) && !q_q[1];
    want_sda = state_q == START  ? q_q[0] :
               state_q == BYTE   ? (!ack_bit && idx_q != 2'd3 && !cur_bit) :
               state_q == RSTART ? q_q == 2'd3 :
               state_q == STOP   ? q_q != 2'd3 : 1'b0;
    // SDA waits one cycle whenever SCL is just being pulled low, so it never moves while SCL is high.
    sda_oe_d = (scl_oe_d && !scl_oe_q) ? sda_oe_q : want_sda;
  end
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;
  assign wr_fin  = wr_fin_q;
  assign wr_ack  = wr_ack_q;
  assign rd_fin  = rd_fin_q;
  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master: directed bench with a behavioural I2C slave that logs START/STOP and bytes with ack level.
module tb_i2c_reg_master;
  localparam int QDIV = 20;
  logic clk = 1'b0;
  logic reset_n;
  logic wr_req = 0, rd_req = 0;
  logic [7:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
  logic wr_fin, wr_ack, rd_fin, rd_ack, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic slv_sda_low, slv_scl_low;
  logic scl_line, sda_line;
  assign scl_line = !scl_oe && !slv_scl_low;
  assign sda_line = !sda_oe && !slv_sda_low;
  i2c_reg_master #(.CLK_FREQ(8_000_000), .I2C_FREQ(100_000), .DEV_ADDR(7'h60)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_fin(wr_fin), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_fin(rd_fin), .rd_ack(rd_ack),
    .scl_oe(scl_oe), .scl_i(scl_line), .sda_oe(sda_oe), .sda_i(sda_line)
  );
  always #5 clk = ~clk;
  bit nack_addr = 0, stretch_en = 0;
  logic [7:0] rd_val = 0;
  int log_q[$];
  int cyc, max_low, first_period, last_gap, min_gap;
  // Slave: events 'h200 = START, 'h201 = STOP, otherwise {ack_level, byte}.
  initial begin : slave
    logic ps, pd, sc, sd, active, first, stx, stretched;
    logic [7:0] sh, txb;
    int bitcnt, bidx, hold, low_run, rise_n, t1, stop_cyc;
    ps = 1; pd = 1; active = 0; first = 0; stx = 0; stretched = 0; sh = 0; txb = 0;
    bitcnt = 0; bidx = 0; hold = 0; low_run = 0; rise_n = 0; t1 = 0; stop_cyc = 0;
    cyc = 0; max_low = 0; first_period = 0; last_gap = 0; min_gap = 1000000;
    slv_sda_low = 0; slv_scl_low = 0;
    forever begin
      @(negedge clk);
      cyc++;
      sc = scl_line; sd = sda_line;
      if (!reset_n) begin
        active = 0; bitcnt = 0; hold = 0; slv_sda_low = 0; slv_scl_low = 0; stop_cyc = cyc;
      end else begin
        if (hold > 0) begin hold--; if (hold == 0) slv_scl_low = 0; end
        low_run = sc ? 0 : low_run + 1;
        if (low_run > max_low) max_low = low_run;
        if (ps && sc && pd && !sd) begin
          if (!active) begin
            last_gap = cyc - stop_cyc;
            if (last_gap < min_gap) min_gap = last_gap;
            rise_n = 0;
          end
          log_q.push_back('h200);
          active = 1; first = 1; stx = 0; bitcnt = 0; bidx = 0; slv_sda_low = 0;
        end else if (ps && sc && !pd && sd) begin
          log_q.push_back('h201);
          active = 0; stop_cyc = cyc; slv_sda_low = 0;
        end else if (active && !ps && sc) begin
          rise_n++;
          if (rise_n == 1) t1 = cyc;
          if (rise_n == 2) first_period = cyc - t1;
          if (bitcnt < 8) begin sh = {sh[6:0], sd}; bitcnt++; end
          else if (bitcnt == 8) begin
            log_q.push_back(int'({sd, sh}));
            if (stx && sd) stx = 0;
            bitcnt = 9;
          end
        end else if (active && ps && !sc) begin
          if (bitcnt == 8) slv_sda_low = !stx && !(first && nack_addr);
          else if (bitcnt == 9) begin
            slv_sda_low = 0; bitcnt = 0; bidx++;
            if (first) begin first = 0; stx = sh[0]; txb = rd_val; end
            if (stx) slv_sda_low = !txb[7];
          end else if (stx) slv_sda_low = !txb[7 - bitcnt];
          if (stretch_en && !stretched && bidx == 1 && bitcnt == 3) begin
            stretched = 1; slv_scl_low = 1; hold = 1000;
          end
        end
      end
      ps = sc; pd = sd;
    end
  end
  int wr_fins = 0, rd_fins = 0, dbl = 0;
  logic last_wr_ack = 0, last_rd_ack = 0;
  logic [7:0] last_rd_data = 0;
  initial begin : fin_mon
    logic pw, pr;
    pw = 0; pr = 0;
    forever begin
      @(negedge clk);
      if (wr_fin) begin wr_fins++; last_wr_ack = wr_ack; end
      if (rd_fin) begin rd_fins++; last_rd_ack = rd_ack; last_rd_data = rd_data; end
      if ((wr_fin && pw) || (rd_fin && pr)) dbl++;
      pw = wr_fin; pr = rd_fin;
    end
  end
  int n_assert = 0, n_fail = 0;
  int exp_q[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_log(input int base, input string tag);
    chk({tag, "_len"}, log_q.size() - base, exp_q.size());
    foreach (exp_q[i]) if (base + i < log_q.size()) chk(tag, log_q[base + i], exp_q[i]);
  endtask
  task automatic tick1();
    @(negedge clk); #1;
  endtask
  task automatic wait_wr(input int n);
    int t = 0;
    while (wr_fins < n && t < 40000) begin tick1(); t++; end
    chk("wr_fin_seen", wr_fins >= n, 1);
  endtask
  task automatic wait_rd(input int n);
    int t = 0;
    while (rd_fins < n && t < 40000) begin tick1(); t++; end
    chk("rd_fin_seen", rd_fins >= n, 1);
  endtask
  initial begin : main
    int base, nlog, t;
    reset_n = 1;
    #1 reset_n = 0;
    repeat (3) tick1();
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_fin", wr_fin, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_fin", rd_fin, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    reset_n = 1;
    // Plain write, request held long after wr_fin to catch a repeated transaction.
    base = log_q.size(); wr_addr = 8'h03; wr_data = 8'h07; wr_req = 1;
    wait_wr(1);
    chk("w1_ack", last_wr_ack, 1);
    repeat (300) tick1();
    wr_req = 0;
    chk("w1_single_fin", wr_fins, 1);
    exp_q = '{'h200, 'h0C0, 'h003, 'h007, 'h201};
    chk_log(base, "w1_log");
    chk("w1_scl_period", first_period, 4 * QDIV);
    chk("w1_gap_after_reset", last_gap >= 4 * QDIV, 1);
    // Read of register 0x00 returning 0x11.
    base = log_q.size(); rd_addr = 8'h00; rd_val = 8'h11; rd_req = 1;
    wait_rd(1);
    rd_req = 0;
    chk("r1_ack", last_rd_ack, 1);
    chk("r1_data", last_rd_data, 8'h11);
    repeat (20) tick1();
    exp_q = '{'h200, 'h0C0, 'h000, 'h200, 'h0C1, 'h111, 'h201};
    chk_log(base, "r1_log");
    // Address NACK on a write, then on a read.
    nack_addr = 1;
    base = log_q.size(); wr_addr = 8'h10; wr_data = 8'h55; wr_req = 1;
    wait_wr(2);
    wr_req = 0;
    chk("w2_nack_ack", last_wr_ack, 0);
    repeat (20) tick1();
    exp_q = '{'h200, 'h1C0, 'h201};
    chk_log(base, "w2_log");
    base = log_q.size(); rd_addr = 8'h05; rd_val = 8'hEE; rd_req = 1;
    wait_rd(2);
    rd_req = 0;
    chk("r2_nack_ack", last_rd_ack, 0);
    chk("r2_data_kept", rd_data, 8'h11);
    repeat (20) tick1();
    exp_q = '{'h200, 'h1C0, 'h201};
    chk_log(base, "r2_log");
    nack_addr = 0;
    // Simultaneous requests: write first, read only after wr_req drops.
    base = log_q.size(); wr_addr = 8'h05; wr_data = 8'h2A; rd_addr = 8'h01; rd_val = 8'hA5;
    wr_req = 1; rd_req = 1;
    wait_wr(3);
    chk("p_write_ack", last_wr_ack, 1);
    chk("p_read_not_yet", rd_fins, 2);
    wr_req = 0;
    wait_rd(3);
    rd_req = 0;
    chk("p_read_ack", last_rd_ack, 1);
    chk("p_read_data", last_rd_data, 8'hA5);
    repeat (20) tick1();
    exp_q = '{'h200, 'h0C0, 'h005, 'h02A, 'h201, 'h200, 'h0C0, 'h001, 'h200, 'h0C1, 'h1A5, 'h201};
    chk_log(base, "p_log");
    // Clock stretching during the second byte.
    stretch_en = 1;
    base = log_q.size(); wr_addr = 8'h03; wr_data = 8'h07; wr_req = 1;
    wait_wr(4);
    wr_req = 0;
    chk("s_ack", last_wr_ack, 1);
    chk("s_stretched", max_low >= 1000, 1);
    repeat (20) tick1();
    exp_q = '{'h200, 'h0C0, 'h003, 'h007, 'h201};
    chk_log(base, "s_log");
    // Reset in the middle of the register byte while both lines are pulled low.
    base = log_q.size(); wr_addr = 8'h44; wr_data = 8'h99; wr_req = 1;
    t = 0;
    while (log_q.size() < base + 2 && t < 20000) begin tick1(); t++; end
    chk("m_second_byte_reached", log_q.size() >= base + 2, 1);
    t = 0;
    while (!(scl_oe && sda_oe) && t < 2000) begin tick1(); t++; end
    chk("m_lines_low_before_reset", scl_oe && sda_oe, 1);
    nlog = log_q.size();
    reset_n = 0;
    #1;
    chk("m_scl_released", scl_oe, 0);
    chk("m_sda_released", sda_oe, 0);
    repeat (5) tick1();
    wr_req = 0;
    reset_n = 1;
    repeat (400) tick1();
    chk("m_no_fin", wr_fins, 4);
    chk("m_no_stop", log_q.size(), nlog);
    // First transaction after reset.
    base = log_q.size(); wr_addr = 8'h03; wr_data = 8'h07; wr_req = 1;
    wait_wr(5);
    wr_req = 0;
    chk("a_ack", last_wr_ack, 1);
    chk("a_gap_after_reset", last_gap >= 4 * QDIV, 1);
    repeat (20) tick1();
    exp_q = '{'h200, 'h0C0, 'h003, 'h007, 'h201};
    chk_log(base, "a_log");
    chk("fin_one_cycle", dbl, 0);
    chk("bus_free_min", min_gap >= 4 * QDIV, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
